// File: rtl/exception_flush_ctrl_if.sv
// Handshake bundle between the exception unit, CP0, the pipeline and fetch,
// as seen by the exception flush controller (master) and its environment (slave).
interface exception_flush_ctrl_if;
    logic        exp_detect;
    logic        exp_is_eret;
    logic [31:0] exp_pc_address;
    logic        dbus_busy;
    logic        muldiv_busy;
    logic        fetch_ready;
    logic        pipe_stall;
    logic        pipe_flush;
    logic        cp0_commit;
    logic        cp0_commit_is_eret;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        drain_timeout;
    logic        busy;

    modport master (
        input  exp_detect, exp_is_eret, exp_pc_address, dbus_busy, muldiv_busy, fetch_ready,
        output pipe_stall, pipe_flush, cp0_commit, cp0_commit_is_eret,
               redirect_valid, redirect_pc, drain_timeout, busy
    );

    modport slave (
        output exp_detect, exp_is_eret, exp_pc_address, dbus_busy, muldiv_busy, fetch_ready,
        input  pipe_stall, pipe_flush, cp0_commit, cp0_commit_is_eret,
               redirect_valid, redirect_pc, drain_timeout, busy
    );
endinterface

// File: rtl/exception_flush_ctrl.sv
// Precise exception/ERET entry sequencer: freeze, drain bus and mul/div activity,
// commit CP0 once, flush the pipeline, then hand the captured target PC to fetch.
module exception_flush_ctrl #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    exception_flush_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        REDIRECT
    } state_t;

    localparam logic [7:0] DRAIN_LIMIT = 8'(DRAIN_TIMEOUT);
    localparam logic [3:0] FLUSH_LIMIT = 4'(FLUSH_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [7:0]  drain_cnt;
    logic [7:0]  drain_cnt_next;
    logic [3:0]  flush_cnt;
    logic [3:0]  flush_cnt_next;
    logic [31:0] target;
    logic [31:0] target_next;
    logic        is_eret;
    logic        is_eret_next;
    logic        timeout_hit;
    logic        any_busy;

    assign any_busy = bus.dbus_busy | bus.muldiv_busy;

    // The faulting instruction must freeze in the very cycle it is detected.
    assign bus.pipe_stall = (state != IDLE) | bus.exp_detect;

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        flush_cnt_next = flush_cnt;
        target_next    = target;
        is_eret_next   = is_eret;
        timeout_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.exp_detect) begin
                    target_next  = bus.exp_pc_address;
                    is_eret_next = bus.exp_is_eret;
                    if (any_busy) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 8'd1;
                    end else begin
                        state_next     = FLUSH;
                        flush_cnt_next = 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (!any_busy) begin
                    state_next     = FLUSH;
                    flush_cnt_next = 4'd1;
                end else if (drain_cnt >= DRAIN_LIMIT) begin
                    state_next     = FLUSH;
                    flush_cnt_next = 4'd1;
                    timeout_hit    = 1'b1;
                end else if (drain_cnt != 8'hFF) begin
                    drain_cnt_next = drain_cnt + 8'd1;
                end
            end
            FLUSH: begin
                if (flush_cnt >= FLUSH_LIMIT) begin
                    state_next = REDIRECT;
                end else if (flush_cnt != 4'hF) begin
                    flush_cnt_next = flush_cnt + 4'd1;
                end
            end
            REDIRECT: begin
                if (bus.fetch_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            drain_cnt              <= 8'd0;
            flush_cnt              <= 4'd0;
            target                 <= 32'd0;
            is_eret                <= 1'b0;
            bus.pipe_flush         <= 1'b0;
            bus.cp0_commit         <= 1'b0;
            bus.cp0_commit_is_eret <= 1'b0;
            bus.redirect_valid     <= 1'b0;
            bus.redirect_pc        <= 32'd0;
            bus.drain_timeout      <= 1'b0;
            bus.busy               <= 1'b0;
        end else begin
            state                  <= state_next;
            drain_cnt              <= drain_cnt_next;
            flush_cnt              <= flush_cnt_next;
            target                 <= target_next;
            is_eret                <= is_eret_next;
            bus.pipe_flush         <= (state_next == FLUSH);
            bus.cp0_commit         <= (state_next == FLUSH) && (state != FLUSH);
            bus.cp0_commit_is_eret <= (state_next == FLUSH) && (state != FLUSH) && is_eret_next;
            bus.redirect_valid     <= (state_next == REDIRECT);
            if (state_next == REDIRECT) begin
                bus.redirect_pc <= target_next;
            end
            bus.drain_timeout      <= bus.drain_timeout | timeout_hit;
            bus.busy               <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_exception_flush_ctrl.sv
// Randomised scoreboard bench for exception_flush_ctrl: each exception transaction
// predicts its commit and redirect events, a monitor pops and compares them.
module tb_exception_flush_ctrl;

    localparam int F = 1;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exception_flush_ctrl_if bus ();

    exception_flush_ctrl #(
        .FLUSH_CYCLES (F),
        .DRAIN_TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          cycle;
        logic        eret;
        logic [31:0] pc;
        logic        timeout;
        int          rv_cycles;
    } event_t;

    event_t commit_q[$];
    event_t redir_q[$];

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    bit sticky     = 1'b0;
    int flush_seen = 0;
    int rv_seen    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.exp_detect     = 1'b0;
            bus.exp_is_eret    = 1'($urandom);
            bus.exp_pc_address = $urandom;
            bus.dbus_busy      = 1'($urandom);
            bus.muldiv_busy    = 1'($urandom);
            bus.fetch_ready    = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // One accepted exception. Bus activity is high for b cycles starting at the detect
    // cycle, so the drain lasts min(b,T) cycles and times out only when b exceeds T.
    // Fetch refuses the redirect for r cycles once it appears.
    task automatic applyStimulus(input logic [31:0] pc, input logic eret, input int b,
                                 input int r, input bit noise);
        int     d;
        int     hs;
        int     c0;
        int     mode;
        event_t e;
        d    = (b < T) ? b : T;
        hs   = d + F + 1 + r;
        c0   = cyc;
        mode = $urandom_range(0, 2);
        if (b > T) sticky = 1'b1;
        e.cycle     = c0 + d + 1;
        e.eret      = eret;
        e.pc        = pc;
        e.timeout   = sticky;
        e.rv_cycles = r + 1;
        commit_q.push_back(e);
        e.cycle = c0 + hs;
        redir_q.push_back(e);
        for (int rel = 0; rel <= hs; rel++) begin
            if (rel == 0) begin
                bus.exp_detect     = 1'b1;
                bus.exp_pc_address = pc;
                bus.exp_is_eret    = eret;
            end else begin
                bus.exp_detect     = noise && ($urandom_range(0, 3) == 0);
                bus.exp_pc_address = ~pc;
                bus.exp_is_eret    = ~eret;
            end
            bus.dbus_busy   = (rel < b) && (mode != 1);
            bus.muldiv_busy = (rel < b) && (mode != 0);
            bus.fetch_ready = (rel >= hs) || ((rel < d + F + 1) && 1'($urandom));
            @(posedge clk);
            #1;
        end
        checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("idle_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    endtask

    task automatic resetDuringDrain();
        bus.exp_detect     = 1'b1;
        bus.exp_pc_address = 32'h1234_5678;
        bus.exp_is_eret    = 1'b0;
        bus.dbus_busy      = 1'b1;
        bus.muldiv_busy    = 1'b0;
        bus.fetch_ready    = 1'b1;
        @(posedge clk);
        #1;
        bus.exp_detect = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.dbus_busy = 1'b0;
        sticky        = 1'b0;
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_drain_timeout", {31'd0, bus.drain_timeout}, 32'd0);
        checkOutput("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        idleCycles(5);
    endtask

    // Monitor: pops predicted events whenever the DUT commits or hands over a redirect.
    always @(negedge clk) begin
        if (rst) begin
            flush_seen = 0;
            rv_seen    = 0;
        end else begin
            checkOutput("pipe_stall", {31'd0, bus.pipe_stall},
                        {31'd0, bus.busy | bus.exp_detect});
            if (bus.pipe_flush) flush_seen++;
            if (bus.cp0_commit) begin
                if (commit_q.size() == 0) begin
                    checkOutput("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    event_t e;
                    e = commit_q.pop_front();
                    checkOutput("commit_cycle", cyc, e.cycle);
                    checkOutput("commit_is_eret", {31'd0, bus.cp0_commit_is_eret}, {31'd0, e.eret});
                    checkOutput("commit_flush", {31'd0, bus.pipe_flush}, 32'd1);
                    checkOutput("drain_timeout", {31'd0, bus.drain_timeout}, {31'd0, e.timeout});
                end
            end
            if (bus.redirect_valid) begin
                rv_seen++;
                if (redir_q.size() == 0) begin
                    checkOutput("unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    checkOutput("redirect_pc", bus.redirect_pc, redir_q[0].pc);
                    if (bus.fetch_ready) begin
                        event_t e;
                        e = redir_q.pop_front();
                        checkOutput("handshake_cycle", cyc, e.cycle);
                        checkOutput("redirect_hold", rv_seen, e.rv_cycles);
                        checkOutput("flush_cycles", flush_seen, F);
                        rv_seen    = 0;
                        flush_seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        rst                = 1'b1;
        bus.exp_detect     = 1'b0;
        bus.exp_is_eret    = 1'b0;
        bus.exp_pc_address = 32'd0;
        bus.dbus_busy      = 1'b0;
        bus.muldiv_busy    = 1'b0;
        bus.fetch_ready    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_flush", {31'd0, bus.pipe_flush}, 32'd0);
        checkOutput("reset_commit", {31'd0, bus.cp0_commit}, 32'd0);
        checkOutput("reset_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        checkOutput("reset_redirect_pc", bus.redirect_pc, 32'd0);
        checkOutput("reset_drain_timeout", {31'd0, bus.drain_timeout}, 32'd0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] directed transactions");
        applyStimulus(32'hBFC0_0380, 1'b0, 0, 0, 1'b0);
        applyStimulus(32'hBFC0_0380, 1'b0, 3, 0, 1'b0);
        applyStimulus(32'h8000_0180, 1'b0, 0, 4, 1'b1);
        applyStimulus(32'h8000_1000, 1'b1, 0, 0, 1'b0);
        applyStimulus(32'hBFC0_0200, 1'b0, T, 1, 1'b1);
        applyStimulus(32'hBFC0_0380, 1'b0, T + 20, 0, 1'b1);
        idleCycles(1);

        $display("[TB] random transactions");
        for (int i = 0; i < 40; i++) begin
            int b;
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(T - 1, T + 3))
                                            : int'($urandom_range(0, 4));
            applyStimulus($urandom, 1'($urandom), b, $urandom_range(0, 3), 1'b1);
            idleCycles($urandom_range(0, 2));
        end

        $display("[TB] reset during drain");
        resetDuringDrain();
        applyStimulus(32'hBFC0_0380, 1'b1, 2, 1, 1'b1);

        for (int i = 0; i < 200 && (commit_q.size() != 0 || redir_q.size() != 0); i++) begin
            @(posedge clk);
        end
        checkOutput("pending_events", commit_q.size() + redir_q.size(), 32'd0);
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
